// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read controller: parameter defaults, FSM state
// encoding and the burst-length legality check.
package fifo_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic len_ok(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Control, FIFO-side and downstream stream signals of the FIFO read controller.
interface fifo_rd_ctrl_if #(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(fifo_pkg::DEPTH_DEF) + 1
);
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             fifo_empty_i;
    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] fifo_rdata_i;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             len_err_o;

    modport slave (
        input  start_i, len_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
        output fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o, len_err_o
    );

    modport master (
        output start_i, len_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
        input  fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o, len_err_o
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between FIFO read data and the downstream valid/ready port.
module fifo_rd_skid #(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    assign pop  = out_valid && out_ready;
    // The controller never overfills; the guard just keeps a full buffer intact.
    assign push = in_valid && ((cnt != 2'd2) || pop);

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst reader: pops len words from a FIFO and streams them out through a
// two-entry skid buffer, keeping at most two words between FIFO and output.
module fifo_rd_ctrl import fifo_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          clr_n_i,
    fifo_rd_ctrl_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic             inflight;
    logic             len_err_q;
    logic [1:0]       occ;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             len_legal;
    logic             start_ok;
    logic             rd_en;
    logic             xfer;

    assign len_legal = len_ok(32'(bus.len_i), DEPTH);
    assign start_ok  = (state == S_IDLE) && bus.start_i && len_legal;
    assign xfer      = skid_valid && bus.m_ready_i;

    // Pop only if buffered + in-flight words, less this cycle's transfer, leave room.
    assign rd_en = (state == S_READ) && !bus.fifo_empty_i && (pop_cnt < len_q) &&
                   (({1'b0, occ} + 3'(inflight)) < (3'd2 + 3'(xfer)));

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_READ;
            S_READ:  if ((pop_cnt + CNT_W'(rd_en)) == len_q) state_nxt = S_DRAIN;
            S_DRAIN: if ((acc_cnt + CNT_W'(xfer)) == len_q) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst length, pop/accept counters, in-flight pop tracker and error pulse.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            len_q     <= '0;
            pop_cnt   <= '0;
            acc_cnt   <= '0;
            inflight  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            inflight  <= rd_en;
            len_err_q <= (state == S_IDLE) && bus.start_i && !len_legal;
            if (start_ok) begin
                len_q   <= bus.len_i;
                pop_cnt <= '0;
                acc_cnt <= '0;
            end else begin
                if (rd_en) pop_cnt <= pop_cnt + CNT_W'(1);
                if (xfer)  acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk_i     (clk_i),
        .clr_n_i   (clr_n_i),
        .in_valid  (inflight),
        .in_data   (bus.fifo_rdata_i),
        .out_valid (skid_valid),
        .out_ready (bus.m_ready_i),
        .out_data  (skid_data),
        .count     (occ)
    );

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = skid_valid;
    assign bus.m_data_o     = skid_data;
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.done_o       = (state == S_DONE);
    assign bus.len_err_o    = len_err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a FIFO model feeds the DUT, written words
// are queued as expected output, and a negedge monitor checks every transfer.
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    localparam int unsigned WIDTH = WIDTH_DEF;
    localparam int unsigned DEPTH = DEPTH_DEF;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic clk_i = 1'b0;
    logic clr_n_i;
    always #5 clk_i = ~clk_i;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fifo_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .clr_n_i (clr_n_i),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] wr_req[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] stall_data;
    logic flush_req = 1'b0;
    bit   stalled   = 1'b0;
    int cyc = 0;
    int n_pops = 0, first_pop = -1, last_pop = -1;
    int n_acc = 0, n_done = 0, n_lerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: pop on rd_en (data appears the next cycle), then accept writes.
    always @(posedge clk_i) begin
        cyc++;
        if (flush_req) fifo_q.delete();
        if (bus.fifo_rd_en_o) begin
            chk("rd_while_empty", int'(bus.fifo_empty_i), 0);
            if (fifo_q.size() != 0) bus.fifo_rdata_i <= fifo_q.pop_front();
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        while (wr_req.size() != 0) fifo_q.push_back(wr_req.pop_front());
        bus.fifo_empty_i <= (fifo_q.size() == 0);
    end

    // Monitor: checks each transfer against the scoreboard and stall stability.
    always @(negedge clk_i) begin
        if (bus.done_o)    n_done++;
        if (bus.len_err_o) n_lerr++;
        if (clr_n_i && stalled) begin
            chk("stall_valid", int'(bus.m_valid_o), 1);
            chk("stall_data", int'(bus.m_data_o), int'(stall_data));
        end
        if (clr_n_i && bus.m_valid_o && bus.m_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_word", int'(bus.m_data_o), -1);
            else                   chk("data", int'(bus.m_data_o), int'(exp_q.pop_front()));
            n_acc++;
        end
        if (clr_n_i && bus.fifo_rd_en_o)
            chk("outstanding_le2", int'((n_pops + 1 - n_acc) <= 2), 1);
        stalled    = clr_n_i && bus.m_valid_o && !bus.m_ready_i;
        stall_data = bus.m_data_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_req.push_back(wdata);
            exp_q.push_back(wdata);
            wdata++;
        end
    endtask

    task automatic clear_stats();
        n_pops = 0; first_pop = -1; last_pop = -1;
        n_acc = 0; n_done = 0; n_lerr = 0;
    endtask

    task automatic start_burst(input int len);
        bus.len_i   = CNT_W'(len);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_rd_en"},   int'(bus.fifo_rd_en_o), 0);
        chk({name, "_m_valid"}, int'(bus.m_valid_o), 0);
        chk({name, "_m_data"},  int'(bus.m_data_o), 0);
        chk({name, "_busy"},    int'(bus.busy_o), 0);
        chk({name, "_done"},    int'(bus.done_o), 0);
        chk({name, "_len_err"}, int'(bus.len_err_o), 0);
    endtask

    // Runs until done_o with a ready pattern, optional late FIFO writes and a
    // stray start pulse, then checks the burst totals.
    task automatic run_to_done(input string name, input int len, input int budget,
                               input int mode, input int extra_at, input int extra_n,
                               input int busy_at, input int busy_len);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (n_done != 0) begin
                ok = 1'b1;
                break;
            end
            bus.m_ready_i = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            bus.start_i   = (c == busy_at);
            if (c == busy_at) bus.len_i = CNT_W'(busy_len);
            if (extra_n > 0 && c == extra_at) begin
                chk({name, "_stall_pops"}, n_pops, len - extra_n);
                chk({name, "_stall_busy"}, int'(bus.busy_o), 1);
                chk({name, "_stall_nodone"}, n_done, 0);
                write_words(extra_n);
            end
            tick();
        end
        bus.start_i   = 1'b0;
        bus.m_ready_i = 1'b1;
        if (!ok) chk({name, "_timeout"}, 0, 1);
        tick();
        tick();
        chk({name, "_done_once"}, n_done, 1);
        chk({name, "_xfers"}, n_acc, len);
        chk({name, "_pops"}, n_pops, len);
        chk({name, "_exp_left"}, exp_q.size(), 0);
        chk({name, "_idle_busy"}, int'(bus.busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_n_i       = 1'b0;
        bus.start_i   = 1'b0;
        bus.len_i     = '0;
        bus.m_ready_i = 1'b0;
        wdata         = WIDTH'(8'h30);
        repeat (3) tick();
        check_idle_outputs("reset");
        clr_n_i = 1'b1;

        // Streaming: 16 words, ready held, consecutive pops and 3-edge latency.
        clear_stats();
        write_words(16);
        bus.m_ready_i = 1'b1;
        tick(); tick();
        start_burst(16);
        chk("busy_rise", int'(bus.busy_o), 1);
        tick();
        chk("latency_not_yet", int'(bus.m_valid_o), 0);
        tick();
        chk("latency_valid", int'(bus.m_valid_o), 1);
        run_to_done("stream", 16, 60, 0, -1, 0, -1, 0);
        chk("stream_consecutive", last_pop - first_pop, 15);

        // Backpressure: ready pattern 1,0,0,1.
        clear_stats();
        write_words(8);
        tick(); tick();
        start_burst(8);
        run_to_done("backpressure", 8, 120, 1, -1, 0, -1, 0);

        // Underrun: 4 of 6 words present, 2 more arrive 20 cycles later.
        clear_stats();
        write_words(4);
        tick(); tick();
        start_burst(6);
        run_to_done("underrun", 6, 100, 0, 20, 2, -1, 0);

        // Illegal lengths 0 and 17 with data waiting in the FIFO.
        clear_stats();
        write_words(2);
        tick(); tick();
        start_burst(0);
        chk("len0_err", int'(bus.len_err_o), 1);
        chk("len0_busy", int'(bus.busy_o), 0);
        tick();
        chk("len0_err_pulse", int'(bus.len_err_o), 0);
        start_burst(17);
        chk("len17_err", int'(bus.len_err_o), 1);
        chk("len17_busy", int'(bus.busy_o), 0);
        tick(); tick();
        chk("illegal_err_count", n_lerr, 2);
        chk("illegal_no_pop", n_pops, 0);
        chk("illegal_busy", int'(bus.busy_o), 0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        exp_q.delete();

        // Reset mid-burst after 5 of 10 transfers, then a fresh burst.
        clear_stats();
        write_words(10);
        tick(); tick();
        start_burst(10);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            #2;
            if (n_acc >= 5) break;
        end
        chk("rst_mid_reached5", int'(n_acc >= 5), 1);
        clr_n_i = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        exp_q.delete();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        clr_n_i = 1'b1;
        clear_stats();
        write_words(4);
        tick(); tick();
        start_burst(4);
        run_to_done("after_rst", 4, 60, 0, -1, 0, -1, 0);

        // Start pulse with len 3 while a len 10 burst is in READ.
        clear_stats();
        write_words(10);
        tick(); tick();
        start_burst(10);
        run_to_done("start_busy", 10, 80, 0, -1, 0, 2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data word width.
REQ-002 DEPTH, default 16, FIFO depth and maximum burst length.
REQ-003 CNT_W, default $clog2(DEPTH)+1, width of the length and count fields.
REQ-004 Ports SHALL be: clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 clr_n_i  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  burst request, sampled in IDLE only.
REQ-007 len_i  in  CNT_W  words to read, legal 1..DEPTH; captured with start_i.
REQ-008 fifo_empty_i  in  1  empty flag from the FIFO.
REQ-009 fifo_rd_en_o  out  1  pop request to the FIFO.
REQ-010 fifo_rdata_i  in  WIDTH  FIFO read data; valid the cycle after a pop.
REQ-011 m_valid_o  out  1  downstream data valid.
REQ-012 m_data_o  out  WIDTH  downstream data.
REQ-013 m_ready_i  in  1  downstream ready.
REQ-014 busy_o  out  1  high from the accepted start until done.
REQ-015 done_o  out  1  one-cycle pulse after the last word is accepted downstream.
REQ-016 len_err_o  out  1  one-cycle pulse when start_i carries len_i==0 or len_i>DEPTH.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-018 IDLE to READ SHALL occur on start_i with a legal len_i; pop count and accept count clear; busy_o rises the next cycle.
REQ-019 An illegal len_i SHALL pulse len_err_o for one cycle, the FSM SHALL stay in IDLE, and no pop SHALL occur.
REQ-020 fifo_rd_en_o SHALL be asserted only in READ, and only when !fifo_empty_i, pops < len, and in-flight plus buffered words < 2.
REQ-021 fifo_rd_en_o SHALL never be asserted while fifo_empty_i is high, so no FIFO read error can occur.
REQ-022 A pop in cycle N SHALL capture fifo_rdata_i into the 2-entry skid buffer in cycle N+1.
REQ-023 m_valid_o SHALL be high whenever the buffer is non-empty; a transfer occurs when m_valid_o and m_ready_i are both high.
REQ-024 Output order SHALL match pop order.
REQ-025 Once m_valid_o is high, m_data_o SHALL stay stable until the transfer completes.
REQ-026 A capture and a transfer in the same cycle SHALL leave the buffer occupancy unchanged.
REQ-027 With m_ready_i held high and the FIFO non-empty, throughput SHALL be 1 word per cycle; first-word latency from start_i SHALL be 3 cycles (start, pop, capture).
REQ-028 When pops reach len, the FSM SHALL go from READ to DRAIN.
REQ-029 When accepted words reach len, the FSM SHALL go from DRAIN to DONE; done_o SHALL pulse in DONE; the FSM SHALL then return to IDLE; busy_o SHALL fall with the return to IDLE.
REQ-030 If the FIFO goes empty mid-burst, the block SHALL stall in READ with no timeout and resume when fifo_empty_i falls.
REQ-031 start_i SHALL be ignored while busy_o is high.
REQ-032 Counters SHALL be CNT_W bits wide, compare against len exactly, and never wrap.

Reset
REQ-033 Asserting clr_n_i low SHALL immediately, without a clock edge, force: state IDLE; counters 0; buffer empty; fifo_rd_en_o 0; m_valid_o 0; m_data_o 0; busy_o 0; done_o 0; len_err_o 0.
REQ-034 Reset asserted mid-burst SHALL discard buffered words; words already popped from the FIFO SHALL be lost.
REQ-035 Reset deassertion SHALL be synchronized externally; the first start_i SHALL be honoured on the first clock edge after release.

Structure
REQ-036 A shared package fifo_pkg SHALL hold the state enum (IDLE, READ, DRAIN, DONE) and the defaults for WIDTH and DEPTH.
REQ-037 The 2-entry output buffer SHALL be a separate sub-module, fifo_rd_skid, with ports clk_i, clr_n_i, in_valid, in_data, out_valid, out_data, out_ready and count.

Verification
REQ-038 Streaming: FIFO preloaded with 16 words, len_i=16, m_ready_i held 1 -> 16 pops on consecutive cycles, data in order, done_o pulses exactly once, fifo_rd_en_o never high while empty.
REQ-039 Backpressure: len_i=8, m_ready_i toggling 1,0,0,1 -> no word lost or duplicated, m_data_o stable while stalled, never more than 2 outstanding pops.
REQ-040 Underrun: 4 words preloaded, len_i=6, 2 more words written 20 cycles later -> stall in READ with no pops while empty, then completion and done_o.
REQ-041 Illegal length: len_i=0, then len_i=17 -> len_err_o pulses each time, busy_o stays 0, no pop.
REQ-042 Reset mid-burst: clr_n_i low after 5 of 10 words -> all outputs 0 immediately, state IDLE; a new start_i then completes normally.
REQ-043 Start while busy: start_i pulsed in READ with len_i=3 -> ignored; the original len_i=10 burst completes with exactly 10 transfers.
